// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the memory-access stage: funct3 access codes,
// writeback-select codes and the LSU state encoding.
package cpu_defs;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] WSEL_LOAD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } acc_size_t;

  // Access width from funct3; the unused encodings 011/110/111 behave as words.
  function automatic acc_size_t f3_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Data-memory port: request/ready for the address phase, rvalid for read data.
interface mem_lsu_if;
  logic        dm_req_o;
  logic        dm_we_o;
  logic [31:0] dm_addr_o;
  logic [3:0]  dm_wstrb_o;
  logic [31:0] dm_wdata_o;
  logic        dm_ready_i;
  logic [31:0] dm_rdata_i;
  logic        dm_rvalid_i;

  modport master (
    output dm_req_o, dm_we_o, dm_addr_o, dm_wstrb_o, dm_wdata_o,
    input  dm_ready_i, dm_rdata_i, dm_rvalid_i
  );

  modport slave (
    input  dm_req_o, dm_we_o, dm_addr_o, dm_wstrb_o, dm_wdata_o,
    output dm_ready_i, dm_rdata_i, dm_rvalid_i
  );
endinterface

// File: rtl/mem_lsu_align.sv
// Purely combinational lane logic: store strobes and lane replication,
// load byte/half extraction with sign/zero extension, and alignment check.
module lsu_align
  import cpu_defs::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        is_store_i,
  input  logic [31:0] sdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ldata_o,
  output logic        misalign_o
);

  acc_size_t   w_size;
  logic        w_unsigned;
  logic [7:0]  w_lane [4];
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_size     = f3_size(funct3_i);
  assign w_unsigned = funct3_i[2];

  // Byte lanes of the read word, and store data replicated so that the
  // selected strobes always see the right bytes regardless of offset.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_lane[gi] = rdata_i[8*gi +: 8];
      assign wdata_o[8*gi +: 8] = (w_size == SZ_BYTE) ? sdata_i[7:0] :
                                  (w_size == SZ_HALF) ? sdata_i[8*(gi%2) +: 8] :
                                                        sdata_i[8*gi +: 8];
    end
  endgenerate

  assign w_byte = w_lane[addr_lo_i];
  assign w_half = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  assign misalign_o = ((w_size == SZ_HALF) & addr_lo_i[0]) |
                      ((w_size == SZ_WORD) & (addr_lo_i != 2'b00));

  // Byte strobes for stores; loads never write.
  always_comb begin
    wstrb_o = 4'b0000;
    if (is_store_i) begin
      case (w_size)
        SZ_BYTE: wstrb_o = 4'b0001 << addr_lo_i;
        SZ_HALF: wstrb_o = 4'b0011 << addr_lo_i;
        default: wstrb_o = 4'b1111;
      endcase
    end
  end

  // Load data extension for the writeback mux.
  always_comb begin
    ldata_o = rdata_i;
    case (w_size)
      SZ_BYTE: ldata_o = {{24{~w_unsigned & w_byte[7]}}, w_byte};
      SZ_HALF: ldata_o = {{16{~w_unsigned & w_half[15]}}, w_half};
      default: ldata_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Memory-access stage load/store unit: runs one bus transaction per memory
// instruction, stalls upstream while it is outstanding and feeds MEM/WB.
module mem_lsu
  import cpu_defs::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic        have_inst_i,
  input  logic [1:0]  rf_wsel_i,
  input  logic        rf_we_i,
  input  logic [4:0]  wR_i,
  input  logic [31:0] wD_i,
  input  logic        mem_re_i,
  input  logic        mem_we_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] sdata_i,
  mem_lsu_if.master   dm,
  output logic        stall_o,
  output logic [31:0] pc_o,
  output logic        have_inst_o,
  output logic [1:0]  rf_wsel_o,
  output logic        rf_we_o,
  output logic [4:0]  wR_o,
  output logic [31:0] wD_o,
  output logic [31:0] rdo_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  localparam int           CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  lsu_state_t    r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_rdo;
  logic          r_bus_err;

  logic        w_acc;
  logic        w_misalign;
  logic        w_tmo;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata;
  logic [31:0] w_ldata;

  assign w_acc = have_inst_i & (mem_re_i | mem_we_i);
  // Counter reaches its last allowed busy cycle; ">=" keeps it safe if the
  // count stepped past the mark on the same cycle the request was accepted.
  assign w_tmo = (r_cnt >= TMO_LAST);

  lsu_align u_align (
    .funct3_i   (funct3_i),
    .addr_lo_i  (wD_i[1:0]),
    .is_store_i (mem_we_i),
    .sdata_i    (sdata_i),
    .rdata_i    (dm.dm_rdata_i),
    .wstrb_o    (w_wstrb),
    .wdata_o    (w_wdata),
    .ldata_o    (w_ldata),
    .misalign_o (w_misalign)
  );

  // Bus side: address/strobes/data follow the held EX/MEM inputs.
  assign dm.dm_req_o   = (r_state == ST_REQ);
  assign dm.dm_we_o    = (r_state == ST_REQ) & mem_we_i;
  assign dm.dm_addr_o  = {wD_i[31:2], 2'b00};
  assign dm.dm_wstrb_o = w_wstrb;
  assign dm.dm_wdata_o = w_wdata;

  // Pipeline side: bubbles downstream while stalled; misaligned accesses and
  // timed-out accesses pass through without a register write.
  assign stall_o     = w_acc & ~w_misalign & (r_state != ST_DONE);
  assign have_inst_o = have_inst_i & ~stall_o;
  assign rf_we_o     = rf_we_i & ~stall_o & ~(w_acc & w_misalign) & ~r_bus_err;
  assign misalign_o  = ~rst & (r_state == ST_IDLE) & w_acc & w_misalign;
  assign bus_err_o   = r_bus_err;
  assign rdo_o       = r_rdo;
  assign pc_o        = pc_i;
  assign rf_wsel_o   = rf_wsel_i;
  assign wR_o        = wR_i;
  assign wD_o        = wD_i;

  // Access sequencer with timeout counter, load-data capture and error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_rdo     <= '0;
      r_bus_err <= 1'b0;
    end else begin
      r_bus_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_acc & ~w_misalign) begin
            r_state <= ST_REQ;
            r_cnt   <= '0;
          end
        end
        ST_REQ: begin
          if (dm.dm_ready_i) begin
            r_state <= mem_we_i ? ST_DONE : ST_RESP;
            r_cnt   <= r_cnt + 1'b1;
          end else if (w_tmo) begin
            r_state   <= ST_DONE;
            r_bus_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (dm.dm_rvalid_i) begin
            r_rdo   <= w_ldata;
            r_state <= ST_DONE;
          end else if (w_tmo) begin
            r_state   <= ST_DONE;
            r_bus_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: a timeline model derived from the memory's
// ready/rvalid delays predicts every output each cycle; a few literal
// checks pin the model to hand-computed values.
module tb_mem_lsu;
  import cpu_defs::*;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        have_inst_i;
  logic [1:0]  rf_wsel_i;
  logic        rf_we_i;
  logic [4:0]  wR_i;
  logic [31:0] wD_i;
  logic        mem_re_i;
  logic        mem_we_i;
  logic [2:0]  funct3_i;
  logic [31:0] sdata_i;
  logic        stall_o;
  logic [31:0] pc_o;
  logic        have_inst_o;
  logic [1:0]  rf_wsel_o;
  logic        rf_we_o;
  logic [4:0]  wR_o;
  logic [31:0] wD_o;
  logic [31:0] rdo_o;
  logic        misalign_o;
  logic        bus_err_o;

  mem_lsu_if dm ();

  mem_lsu #(.TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_i        (pc_i),
    .have_inst_i (have_inst_i),
    .rf_wsel_i   (rf_wsel_i),
    .rf_we_i     (rf_we_i),
    .wR_i        (wR_i),
    .wD_i        (wD_i),
    .mem_re_i    (mem_re_i),
    .mem_we_i    (mem_we_i),
    .funct3_i    (funct3_i),
    .sdata_i     (sdata_i),
    .dm          (dm),
    .stall_o     (stall_o),
    .pc_o        (pc_o),
    .have_inst_o (have_inst_o),
    .rf_wsel_o   (rf_wsel_o),
    .rf_we_o     (rf_we_o),
    .wR_o        (wR_o),
    .wD_o        (wD_o),
    .rdo_o       (rdo_o),
    .misalign_o  (misalign_o),
    .bus_err_o   (bus_err_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int obs_stall = 0;
  logic chk_en = 1'b0;

  // Expected per-cycle outputs, set by the stimulus just after each posedge.
  logic        exp_stall, exp_req, exp_we, exp_have, exp_rfwe, exp_mis, exp_err;
  logic [31:0] exp_rdo;
  logic [3:0]  exp_strb;
  logic [31:0] exp_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at t=%0t", name, act, req, $time);
    end
  endtask

  // ---- reference rules, in plain arithmetic ----
  function automatic int m_bytes(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit m_misal(input logic [2:0] f3, input logic [1:0] a);
    return (int'(a) % m_bytes(f3)) != 0;
  endfunction

  function automatic logic [3:0] m_strb(input logic st, input logic [2:0] f3, input logic [1:0] a);
    int v;
    if (!st) return 4'b0000;
    v = ((1 << m_bytes(f3)) - 1) << int'(a);
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
    case (m_bytes(f3))
      1:       return {24'd0, sd[7:0]} * 32'h01010101;
      2:       return {16'd0, sd[15:0]} * 32'h00010001;
      default: return sd;
    endcase
  endfunction

  function automatic logic [31:0] m_ext(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] rd);
    logic [31:0] sh;
    sh = rd >> (8 * int'(a));
    case (m_bytes(f3))
      1:       return f3[2] ? {24'd0, sh[7:0]}  : 32'($signed(sh[7:0]));
      2:       return f3[2] ? {16'd0, sh[15:0]} : 32'($signed(sh[15:0]));
      default: return rd;
    endcase
  endfunction

  // ---- single compare process ----
  always @(negedge clk) begin
    if (chk_en) begin
      if (stall_o) obs_stall++;
      chk("stall_o",     32'(stall_o),     32'(exp_stall));
      chk("dm_req_o",    32'(dm.dm_req_o), 32'(exp_req));
      chk("have_inst_o", 32'(have_inst_o), 32'(exp_have));
      chk("rf_we_o",     32'(rf_we_o),     32'(exp_rfwe));
      chk("misalign_o",  32'(misalign_o),  32'(exp_mis));
      chk("bus_err_o",   32'(bus_err_o),   32'(exp_err));
      chk("rdo_o",       rdo_o,            exp_rdo);
      chk("pc_o",        pc_o,             pc_i);
      chk("wD_o",        wD_o,             wD_i);
      chk("wR_o",        32'(wR_o),        32'(wR_i));
      chk("rf_wsel_o",   32'(rf_wsel_o),   32'(rf_wsel_i));
      if (exp_req) begin
        chk("dm_we_o",    32'(dm.dm_we_o),    32'(exp_we));
        chk("dm_addr_o",  dm.dm_addr_o,       wD_i & 32'hFFFF_FFFC);
        chk("dm_wstrb_o", 32'(dm.dm_wstrb_o), 32'(exp_strb));
        chk("dm_wdata_o", dm.dm_wdata_o,      exp_wdata);
      end
    end
  end

  task automatic set_exp(input logic s, input logic rq, input logic h, input logic we,
                         input logic mi, input logic er);
    exp_stall = s; exp_req = rq; exp_have = h; exp_rfwe = we; exp_mis = mi; exp_err = er;
  endtask

  task automatic set_inst(input logic h, input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sd, input logic we);
    have_inst_i = h; mem_re_i = ld; mem_we_i = st; funct3_i = f3;
    wD_i = addr; sdata_i = sd; rf_we_i = we; wR_i = 5'd7;
    rf_wsel_i = ld ? WSEL_LOAD : 2'd0;
  endtask

  // One memory instruction. R = REQ cycle on which ready is given (0 = never),
  // V = cycles after ready until rvalid (0 = never). The model derives the
  // number of busy cycles N and whether the access times out.
  task automatic mem_op(input string nm, input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] sd, input logic [31:0] rd,
                        input int r, input int v, input logic we);
    bit aligned;
    int need, n, req_last, last;
    bit err;
    aligned  = !m_misal(f3, addr[1:0]);
    need     = (r == 0 || (!st && v == 0)) ? 1000 : (st ? r : r + v);
    err      = need > TMO;
    n        = err ? TMO : need;
    req_last = (r > 0 && r <= n) ? r : n;
    last     = aligned ? n + 1 : 0;
    pc_i     = pc_i + 32'd4;
    for (int c = 0; c <= last; c++) begin
      @(posedge clk); #1;
      set_inst(1'b1, ld, st, f3, addr, sd, we);
      exp_we    = st;
      exp_strb  = m_strb(st, f3, addr[1:0]);
      exp_wdata = m_wdata(f3, sd);
      dm.dm_ready_i  = aligned && r > 0 && c == r && r <= n;
      dm.dm_rvalid_i = aligned && ld && !st && !err && v > 0 && c == r + v;
      dm.dm_rdata_i  = dm.dm_rvalid_i ? rd : 32'hA5A5_0F0F;
      if (!aligned) begin
        set_exp(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      end else begin
        set_exp(c <= n, c >= 1 && c <= req_last, c == n + 1,
                c == n + 1 && we && !err, 1'b0, c == n + 1 && err);
        if (c == n + 1 && ld && !st && !err) exp_rdo = m_ext(f3, addr[1:0], rd);
      end
    end
    $display("txn %s addr=%h f3=%b busy=%0d err=%0d aligned=%0d", nm, addr, f3,
             aligned ? n : 0, err, aligned);
  endtask

  task automatic alu_op(input string nm, input logic [31:0] res);
    @(posedge clk); #1;
    pc_i = pc_i + 32'd4;
    set_inst(1'b1, 1'b0, 1'b0, F3_W, res, 32'd0, 1'b1);
    dm.dm_ready_i = 1'b0; dm.dm_rvalid_i = 1'b0;
    set_exp(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    $display("txn %s result=%h", nm, res);
  endtask

  task automatic lit_after(input string nm, input logic [31:0] act_sel, input logic [31:0] req);
    chk(nm, act_sel, req);
  endtask

  initial begin
    rst = 1'b1;
    pc_i = 32'h0000_1000;
    set_inst(1'b0, 1'b0, 1'b0, F3_W, 32'd0, 32'd0, 1'b0);
    dm.dm_ready_i = 1'b0; dm.dm_rvalid_i = 1'b0; dm.dm_rdata_i = 32'd0;
    set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_we = 1'b0; exp_strb = 4'd0; exp_wdata = 32'd0; exp_rdo = 32'd0;

    // Reset state.
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    $display("txn reset");
    rst = 1'b0;

    // LW 0x100: ready on first REQ cycle, rvalid one cycle later.
    obs_stall = 0;
    mem_op("LW", 1'b1, 1'b0, F3_W, 32'h100, 32'd0, 32'hDEADBEEF, 1, 1, 1'b1);
    @(negedge clk); #1;
    lit_after("lw_rdo", rdo_o, 32'hDEADBEEF);
    lit_after("lw_stall_cycles", 32'(obs_stall), 32'd3);

    // Byte loads from lane 3.
    mem_op("LB", 1'b1, 1'b0, F3_B, 32'h103, 32'd0, 32'h80FF1234, 1, 1, 1'b1);
    @(negedge clk); #1;
    lit_after("lb_rdo", rdo_o, 32'hFFFFFF80);
    mem_op("LBU", 1'b1, 1'b0, F3_BU, 32'h103, 32'd0, 32'h80FF1234, 1, 1, 1'b1);
    @(negedge clk); #1;
    lit_after("lbu_rdo", rdo_o, 32'h00000080);

    // Half loads from the upper half, slower memory up to the timeout limit.
    mem_op("LH", 1'b1, 1'b0, F3_H, 32'h202, 32'd0, 32'h8001_7777, 2, 2, 1'b1);
    mem_op("LHU", 1'b1, 1'b0, F3_HU, 32'h202, 32'd0, 32'h8001_7777, 1, 2, 1'b1);

    // SH at 0x102.
    mem_op("SH", 1'b0, 1'b1, F3_H, 32'h102, 32'h0000ABCD, 32'd0, 1, 0, 1'b0);
    @(negedge clk); #1;
    lit_after("sh_wstrb", 32'(dm.dm_wstrb_o), 32'h0000000C);
    lit_after("sh_wdata", dm.dm_wdata_o, 32'hABCDABCD);
    lit_after("sh_addr", dm.dm_addr_o, 32'h00000100);

    // Other stores.
    mem_op("SB", 1'b0, 1'b1, F3_B, 32'h301, 32'h1234_5677, 32'd0, 2, 0, 1'b0);
    mem_op("SW", 1'b0, 1'b1, F3_W, 32'h304, 32'hCAFE_F00D, 32'd0, 3, 0, 1'b0);

    // Misaligned accesses: no bus activity, no register write.
    mem_op("LW_mis", 1'b1, 1'b0, F3_W, 32'h101, 32'd0, 32'd0, 1, 1, 1'b1);
    @(negedge clk); #1;
    lit_after("mis_pulse", 32'(misalign_o), 32'd1);
    lit_after("mis_req", 32'(dm.dm_req_o), 32'd0);
    mem_op("SH_mis", 1'b0, 1'b1, F3_H, 32'h105, 32'h55AA, 32'd0, 1, 0, 1'b0);

    // Timeouts: ready never comes, then rvalid never comes.
    mem_op("LW_tmo_req", 1'b1, 1'b0, F3_W, 32'h400, 32'd0, 32'd0, 0, 0, 1'b1);
    @(negedge clk); #1;
    lit_after("tmo_bus_err", 32'(bus_err_o), 32'd1);
    lit_after("tmo_rf_we", 32'(rf_we_o), 32'd0);
    mem_op("LW_tmo_resp", 1'b1, 1'b0, F3_W, 32'h404, 32'd0, 32'd0, 1, 0, 1'b1);
    mem_op("ADD_after_tmo", 1'b1, 1'b0, F3_W, 32'h408, 32'd0, 32'h0BAD_CAFE, 1, 1, 1'b1);

    // Reset in RESP, then a stray response.
    pc_i = pc_i + 32'd4;
    @(posedge clk); #1;
    set_inst(1'b1, 1'b1, 1'b0, F3_W, 32'h500, 32'd0, 1'b1);
    dm.dm_ready_i = 1'b0; dm.dm_rvalid_i = 1'b0;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    dm.dm_ready_i = 1'b1;
    set_exp(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_we = 1'b0; exp_strb = 4'd0; exp_wdata = 32'd0;
    @(posedge clk); #1;
    dm.dm_ready_i = 1'b0;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    set_inst(1'b0, 1'b0, 1'b0, F3_W, 32'h0, 32'd0, 1'b0);
    set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_rdo = 32'd0;
    dm.dm_rvalid_i = 1'b1; dm.dm_rdata_i = 32'h1234_5678;
    @(posedge clk); #1;
    dm.dm_rvalid_i = 1'b0;
    $display("txn reset_in_resp stray_rvalid");
    alu_op("ADD0", 32'h0000_0011);
    alu_op("ADD1", 32'h0000_0022);
    mem_op("LW_after_rst", 1'b1, 1'b0, F3_W, 32'h600, 32'd0, 32'h0F0F_1234, 1, 1, 1'b1);

    @(posedge clk); #1;
    set_inst(1'b0, 1'b0, 1'b0, F3_W, 32'h0, 32'd0, 1'b0);
    set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Memory-access stage load/store unit. Sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Converts load/store requests into a req/ready/rvalid transaction on the data-memory port. Generates byte strobes and sign/zero-extended load data (rdo) for the writeback mux.
- Stalls the upstream pipeline while an access is outstanding and inserts bubbles downstream meanwhile.

Parameters:
- TIMEOUT, 255, max cycles spent in REQ or RESP before the access is abandoned with bus_err_o.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- pc_i  in  32  instruction PC from EX/MEM
- have_inst_i  in  1  valid instruction in stage
- rf_wsel_i  in  2  writeback select (3 = load data)
- rf_we_i  in  1  register write enable
- wR_i  in  5  destination register
- wD_i  in  32  ALU result / effective address
- mem_re_i  in  1  load
- mem_we_i  in  1  store
- funct3_i  in  3  access size/sign
- sdata_i  in  32  store data (rs2)
- dm_req_o  out  1  bus request
- dm_we_o  out  1  bus write
- dm_addr_o  out  32  word-aligned address
- dm_wstrb_o  out  4  byte strobes
- dm_wdata_o  out  32  lane-shifted store data
- dm_ready_i  in  1  request accepted
- dm_rdata_i  in  32  read word
- dm_rvalid_i  in  1  read data valid
- stall_o  out  1  hold PC/IF/ID/EX/EX-MEM
- pc_o, have_inst_o, rf_wsel_o, rf_we_o, wR_o, wD_o  out  32/1/2/1/5/32  to MEM/WB
- rdo_o  out  32  extended load data
- misalign_o  out  1  one-cycle misaligned-access pulse
- bus_err_o  out  1  one-cycle timeout pulse

Behaviour:
- Clock/reset: single clock clk; reset rst is synchronous, active-high. Reset forces state IDLE, rdo_o=0, timeout counter=0, misalign_o=0, bus_err_o=0.
- Reset mid-access: abandons the transaction. A dm_rvalid_i arriving later in any state other than RESP is ignored.
- acc = have_inst_i & (mem_re_i | mem_we_i).
- misaligned when:
  - funct3[1:0]=01 and wD_i[0]=1;
  - funct3[1:0]=10 and wD_i[1:0]!=0.
  - funct3 values 011, 110, 111 are treated as LW/SW size.
- FSM states: IDLE, REQ, RESP, DONE.
  - IDLE, acc, aligned: go to REQ; stall_o=1.
  - IDLE, acc, misaligned: stay IDLE; misalign_o=1 for that cycle; no bus activity; instruction passes downstream with rf_we_o=0; stall_o=0.
  - REQ: dm_req_o=1; address/strobes/data stable.
    - dm_ready_i=1: store goes to DONE, load goes to RESP.
  - RESP: on dm_rvalid_i, capture the extended load into rdo_o and go to DONE. dm_rvalid_i coincident with dm_ready_i in REQ is not legal; the memory responds at least one cycle later.
  - DONE: stall_o=0; outputs pass to MEM/WB; go to IDLE.
  - Timeout: counter clears on entering REQ and counts in REQ/RESP. Reaching TIMEOUT gives bus_err_o=1 and goes to DONE with rf_we_o=0 and rdo_o unchanged.
- stall_o = acc & aligned & (state!=DONE).
- have_inst_o = have_inst_i & ~stall_o, giving bubbles while stalled. rf_we_o is likewise gated by ~stall_o.
- pc_o, rf_wsel_o, wR_o, wD_o are combinational pass-through. The MEM/WB register holds the registered copy.
- Minimum latency: load 4 cycles, store 3 cycles; non-memory instruction 0 added cycles.
- dm_addr_o = {wD_i[31:2],2'b00}.
- wstrb:
  - SB: 0001<<a[1:0]
  - SH: 0011<<a[1:0]
  - SW: 1111
  - loads: 0000
- dm_wdata_o:
  - SB: byte replicated x4
  - SH: half replicated x2
  - SW: as-is
- Load extract uses the byte/half lane chosen by a[1:0].
  - LB/LH sign-extend.
  - LBU/LHU zero-extend.
  - LW is the full word.
- rdo_o holds its value outside RESP captures.

Decomposition:
- Shared package cpu_defs: funct3 codes (F3_B, F3_H, F3_W, F3_BU, F3_HU), rf_wsel codes (WSEL_LOAD=2'd3), LSU state encoding.
- One combinational sub-module, lsu_align, computes strobes, store-lane shift, load extension and the misalign check. The FSM, counter and rdo register stay in mem_lsu.

Test Plan:
- LW at 0x100, dm_ready_i on the first REQ cycle, rvalid one cycle later with 0xDEADBEEF -> rdo_o=0xDEADBEEF; stall_o high 3 cycles; have_inst_o=1 only in DONE.
- LB at 0x103 with rdata 0x80FF1234 -> rdo_o=0xFFFFFF80. LBU at the same address -> rdo_o=0x00000080.
- SH at 0x102 with sdata 0x0000ABCD -> dm_wstrb_o=1100, dm_wdata_o=0xABCDABCD, dm_addr_o=0x100; completes the cycle after ready.
- LW at 0x101 -> misalign_o pulse, dm_req_o never asserted, stall_o=0, rf_we_o=0.
- Load with dm_ready_i held 0 and TIMEOUT=4 -> bus_err_o pulse after 4 REQ cycles, then IDLE, rf_we_o=0.
- rst asserted in RESP, then stray dm_rvalid_i -> state IDLE, rdo_o=0, stray response ignored; back-to-back ADD passes with stall_o=0.
